// File: rtl/pong_ball_engine.sv
// Ball kinematics and rally sequencer: serve wait, play, point scoring and game over.
// Optional macro BALL_SPEEDUP_EN: paddle hits speed up |vx| and steer vy from the hit offset.
module pong_ball_engine #(
    parameter int unsigned COORD_W     = 10,
    parameter int unsigned SCREEN_W    = 640,
    parameter int unsigned SCREEN_H    = 480,
    parameter int unsigned BALL_RADIUS = 4,
    parameter int unsigned PADDLE_HALF = 8,
    parameter int unsigned P1_X        = 50,
    parameter int unsigned P2_X        = 590,
    parameter int unsigned VEL_W       = 4,
    parameter int unsigned VEL_INIT    = 2,
    parameter int unsigned VEL_MAX     = 7,
    parameter int unsigned SCORE_W     = 4,
    parameter int unsigned WIN_SCORE   = 11,
    parameter int unsigned SERVE_DELAY = 60
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               frame_tick_i,
    input  logic               serve_i,
    input  logic [COORD_W-1:0] paddle1_y_i,
    input  logic [COORD_W-1:0] paddle2_y_i,
    output logic [COORD_W-1:0] ball_x_o,
    output logic [COORD_W-1:0] ball_y_o,
    output logic [SCORE_W-1:0] score1_o,
    output logic [SCORE_W-1:0] score2_o,
    output logic               point_p1_o,
    output logic               point_p2_o,
    output logic               in_play_o,
    output logic               game_over_o
);
    localparam int unsigned EW    = COORD_W + 2;
    localparam int unsigned CNT_W = $clog2(SERVE_DELAY + 1);

    localparam logic [COORD_W-1:0] CX    = COORD_W'(SCREEN_W / 2);
    localparam logic [COORD_W-1:0] CY    = COORD_W'(SCREEN_H / 2);
    localparam logic [COORD_W-1:0] Y_TOP = COORD_W'(BALL_RADIUS);
    localparam logic [COORD_W-1:0] Y_BOT = COORD_W'(SCREEN_H - 1 - BALL_RADIUS);
    localparam logic [COORD_W-1:0] X_P1  = COORD_W'(P1_X + BALL_RADIUS);
    localparam logic [COORD_W-1:0] X_P2  = COORD_W'(P2_X - BALL_RADIUS);

    // Edge tests are rewritten on the ball centre: e.g. ny-R < 0 becomes ny < R.
    localparam logic signed [EW-1:0] S_Y_TOP = EW'(BALL_RADIUS);
    localparam logic signed [EW-1:0] S_Y_BOT = EW'(SCREEN_H - 1 - BALL_RADIUS);
    localparam logic signed [EW-1:0] S_X_P1  = EW'(P1_X + BALL_RADIUS);
    localparam logic signed [EW-1:0] S_X_P2  = EW'(P2_X - BALL_RADIUS);
    localparam logic signed [EW-1:0] S_X_L   = EW'(BALL_RADIUS);
    localparam logic signed [EW-1:0] S_X_R   = EW'(SCREEN_W - 1 - BALL_RADIUS);
    localparam logic signed [EW-1:0] S_REACH = EW'(PADDLE_HALF + BALL_RADIUS);

    localparam logic signed [VEL_W-1:0] V_INIT = VEL_W'(VEL_INIT);
    localparam logic signed [VEL_W-1:0] V_ONE  = VEL_W'(1);
    localparam logic [SCORE_W-1:0]      WINS   = SCORE_W'(WIN_SCORE);

    typedef enum logic [2:0] {StIdle, StServeWait, StPlay, StPoint, StGameOver} state_e;

    state_e                    state_q, state_d;
    logic [COORD_W-1:0]        x_q, x_d, y_q, y_d;
    logic signed [VEL_W-1:0]   vx_q, vx_d, vy_q, vy_d;
    logic [SCORE_W-1:0]        s1_q, s1_d, s2_q, s2_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic                      dir_q, dir_d;       // 1: next restart serves toward P1
    logic                      scorer_q, scorer_d; // 1: player 1 took the point

    logic signed [EW-1:0]      xs, ys, nx, ny, d1, d2, ad1, ad2;
    logic                      hit1, hit2, miss1, miss2;
    logic [COORD_W-1:0]        x_play, y_play;
    logic signed [VEL_W-1:0]   vx_hit, vy_pad, vy_play;
    logic [SCORE_W-1:0]        s1_inc, s2_inc, s_new;

    always_comb begin
        xs  = signed'({2'b00, x_q});
        ys  = signed'({2'b00, y_q});
        nx  = xs + {{(EW-VEL_W){vx_q[VEL_W-1]}}, vx_q};
        ny  = ys + {{(EW-VEL_W){vy_q[VEL_W-1]}}, vy_q};
        d1  = ys - signed'({2'b00, paddle1_y_i});
        d2  = ys - signed'({2'b00, paddle2_y_i});
        ad1 = d1[EW-1] ? -d1 : d1;
        ad2 = d2[EW-1] ? -d2 : d2;

        hit1  = vx_q[VEL_W-1] && (xs >= S_X_P1) && (nx <= S_X_P1) && (ad1 <= S_REACH);
        hit2  = !vx_q[VEL_W-1] && (vx_q != '0) && (xs <= S_X_P2) && (nx >= S_X_P2)
                && (ad2 <= S_REACH);
        miss2 = !hit1 && !hit2 && (nx <= S_X_L);
        miss1 = !hit1 && !hit2 && !miss2 && (nx >= S_X_R);

`ifdef BALL_SPEEDUP_EN
        begin
            logic signed [VEL_W-1:0] vabs, vfast;
            logic signed [EW-1:0]    doff;
            vabs   = vx_q[VEL_W-1] ? -vx_q : vx_q;
            vfast  = (vabs >= VEL_W'(VEL_MAX)) ? VEL_W'(VEL_MAX) : vabs + V_ONE;
            vx_hit = hit1 ? vfast : -vfast;
            doff   = hit1 ? d1 : d2;
            if (doff[EW-1])     vy_pad = -V_ONE;
            else if (doff != 0) vy_pad = V_ONE;
            else                vy_pad = vy_q;
        end
`else
        vx_hit = -vx_q;
        vy_pad = vy_q;
`endif

        x_play = hit1 ? X_P1 : (hit2 ? X_P2 : nx[COORD_W-1:0]);
        // A wall bounce overrides any paddle steering of vy in the same frame.
        if (ny < S_Y_TOP) begin
            y_play  = Y_TOP;
            vy_play = -vy_q;
        end else if (ny > S_Y_BOT) begin
            y_play  = Y_BOT;
            vy_play = -vy_q;
        end else begin
            y_play  = ny[COORD_W-1:0];
            vy_play = (hit1 || hit2) ? vy_pad : vy_q;
        end

        s1_inc = (s1_q >= WINS) ? s1_q : s1_q + SCORE_W'(1);
        s2_inc = (s2_q >= WINS) ? s2_q : s2_q + SCORE_W'(1);
        s_new  = scorer_q ? s1_inc : s2_inc;
    end

    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        y_d      = y_q;
        vx_d     = vx_q;
        vy_d     = vy_q;
        s1_d     = s1_q;
        s2_d     = s2_q;
        cnt_d    = cnt_q;
        dir_d    = dir_q;
        scorer_d = scorer_q;
        unique case (state_q)
            StIdle: begin
                if (serve_i) begin
                    state_d = StServeWait;
                    cnt_d   = '0;
                end
            end
            StServeWait: begin
                if (frame_tick_i) begin
                    if (cnt_q == CNT_W'(SERVE_DELAY - 1)) begin
                        state_d = StPlay;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            StPlay: begin
                if (frame_tick_i) begin
                    if (miss1 || miss2) begin
                        state_d  = StPoint;
                        scorer_d = miss1;
                    end else begin
                        x_d  = x_play;
                        y_d  = y_play;
                        vx_d = (hit1 || hit2) ? vx_hit : vx_q;
                        vy_d = vy_play;
                    end
                end
            end
            StPoint: begin
                if (scorer_q) s1_d = s1_inc;
                else          s2_d = s2_inc;
                dir_d = ~scorer_q;
                if (s_new == WINS) begin
                    state_d = StGameOver;
                end else begin
                    state_d = StServeWait;
                    cnt_d   = '0;
                    x_d     = CX;
                    y_d     = CY;
                    vx_d    = scorer_q ? V_INIT : -V_INIT;
                    vy_d    = V_ONE;
                end
            end
            StGameOver: begin
                if (serve_i) begin
                    state_d = StServeWait;
                    cnt_d   = '0;
                    s1_d    = '0;
                    s2_d    = '0;
                    x_d     = CX;
                    y_d     = CY;
                    vx_d    = dir_q ? -V_INIT : V_INIT;
                    vy_d    = V_ONE;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= StIdle;
            x_q      <= CX;
            y_q      <= CY;
            vx_q     <= V_INIT;
            vy_q     <= V_ONE;
            s1_q     <= '0;
            s2_q     <= '0;
            cnt_q    <= '0;
            dir_q    <= 1'b0;
            scorer_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            x_q      <= x_d;
            y_q      <= y_d;
            vx_q     <= vx_d;
            vy_q     <= vy_d;
            s1_q     <= s1_d;
            s2_q     <= s2_d;
            cnt_q    <= cnt_d;
            dir_q    <= dir_d;
            scorer_q <= scorer_d;
        end
    end

    assign ball_x_o    = x_q;
    assign ball_y_o    = y_q;
    assign score1_o    = s1_q;
    assign score2_o    = s2_q;
    assign point_p1_o  = (state_q == StPoint) && scorer_q;
    assign point_p2_o  = (state_q == StPoint) && !scorer_q;
    assign in_play_o   = (state_q == StPlay);
    assign game_over_o = (state_q == StGameOver);

endmodule

// File: tb/tb_pong_ball_engine.sv
// Scoreboard bench for pong_ball_engine: an integer rally model predicts each frame's outputs.
module tb_pong_ball_engine;
    logic       clk = 1'b0;
    logic       rst_n, frame_tick, serve;
    logic [9:0] p1y, p2y, ball_x, ball_y;
    logic [3:0] score1, score2;
    logic       point_p1, point_p2, in_play, game_over;

    always #5 clk = ~clk;

    pong_ball_engine dut (
        .clk_i(clk), .rst_ni(rst_n), .frame_tick_i(frame_tick), .serve_i(serve),
        .paddle1_y_i(p1y), .paddle2_y_i(p2y), .ball_x_o(ball_x), .ball_y_o(ball_y),
        .score1_o(score1), .score2_o(score2), .point_p1_o(point_p1), .point_p2_o(point_p2),
        .in_play_o(in_play), .game_over_o(game_over)
    );

    typedef struct packed {
        logic [9:0] x; logic [9:0] y; logic [3:0] s1; logic [3:0] s2;
        logic p1; logic p2; logic ip; logic go;
    } obs_t;

    obs_t exp_q[$];
    int   checks = 0, errors = 0;
    int   n_p1 = 0, n_p2 = 0;
    bit   trk1 = 0, trk2 = 0;

    always @(negedge clk) begin
        if (point_p1) n_p1++;
        if (point_p2) n_p2++;
    end

    // Model state: 0 idle, 1 serve wait, 2 play, 3 point, 4 game over
    int m_st, m_x, m_y, m_vx, m_vy, m_s1, m_s2, m_cnt, m_dir, m_scorer;
    int m_np1 = 0, m_np2 = 0;

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    function automatic void model_reset();
        m_st = 0; m_x = 320; m_y = 240; m_vx = 2; m_vy = 1;
        m_s1 = 0; m_s2 = 0; m_cnt = 0; m_dir = 0; m_scorer = 0;
    endfunction

    function automatic void model_step(input bit tk, input bit sv, input int a, input int b);
        int nx, ny, nvx, vpad, sp, ns;
        bit h1, h2;
        case (m_st)
            0: if (sv) begin m_st = 1; m_cnt = 0; end
            1: if (tk) begin
                if (m_cnt == 59) begin m_st = 2; m_cnt = 0; end
                else m_cnt++;
            end
            2: if (tk) begin
                nx = m_x + m_vx; ny = m_y + m_vy;
                h1 = (m_vx < 0) && (m_x - 4 >= 50) && (nx - 4 <= 50) && (iabs(m_y - a) <= 12);
                h2 = (m_vx > 0) && (m_x + 4 <= 590) && (nx + 4 >= 590) && (iabs(m_y - b) <= 12);
                if (!h1 && !h2 && nx - 4 <= 0) begin
                    m_st = 3; m_scorer = 2; m_np2++;
                end else if (!h1 && !h2 && nx + 4 >= 639) begin
                    m_st = 3; m_scorer = 1; m_np1++;
                end else begin
                    nvx = m_vx; vpad = m_vy;
                    if (h1 || h2) begin
`ifdef BALL_SPEEDUP_EN
                        sp = iabs(m_vx) + 1;
                        if (sp > 7) sp = 7;
                        nvx = h1 ? sp : -sp;
                        if (m_y < (h1 ? a : b)) vpad = -1;
                        else if (m_y > (h1 ? a : b)) vpad = 1;
`else
                        sp = 0;
                        nvx = -m_vx;
`endif
                    end
                    m_x = h1 ? 54 : (h2 ? 586 : nx);
                    if (ny - 4 < 0) begin m_y = 4; m_vy = -m_vy; end
                    else if (ny + 4 > 479) begin m_y = 475; m_vy = -m_vy; end
                    else begin m_y = ny; m_vy = vpad; end
                    m_vx = nvx;
                end
            end
            3: begin
                if (m_scorer == 1) begin if (m_s1 < 11) m_s1++; ns = m_s1; end
                else begin if (m_s2 < 11) m_s2++; ns = m_s2; end
                m_dir = (m_scorer == 2) ? 1 : 0;
                if (ns == 11) m_st = 4;
                else begin
                    m_st = 1; m_cnt = 0; m_x = 320; m_y = 240; m_vy = 1;
                    m_vx = (m_scorer == 1) ? 2 : -2;
                end
            end
            4: if (sv) begin
                m_st = 1; m_cnt = 0; m_s1 = 0; m_s2 = 0; m_x = 320; m_y = 240; m_vy = 1;
                m_vx = m_dir ? -2 : 2;
            end
            default: m_st = 0;
        endcase
    endfunction

    function automatic obs_t model_obs();
        return {10'(m_x), 10'(m_y), 4'(m_s1), 4'(m_s2), (m_st == 3) && (m_scorer == 1),
                (m_st == 3) && (m_scorer == 2), m_st == 2, m_st == 4};
    endfunction

    function automatic obs_t dut_obs();
        return {ball_x, ball_y, score1, score2, point_p1, point_p2, in_play, game_over};
    endfunction

    function automatic string show(input obs_t o);
        return $sformatf("x=%0d y=%0d s1=%0d s2=%0d p1=%b p2=%b play=%b over=%b",
                         o.x, o.y, o.s1, o.s2, o.p1, o.p2, o.ip, o.go);
    endfunction

    // One video frame: tick clock plus three idle clocks; expected state queued at the end.
    task automatic frame(input bit sv);
        p1y = trk1 ? 10'(m_y + 3) : 10'd1023;
        p2y = trk2 ? 10'(m_y - 2) : 10'd1023;
        frame_tick = 1'b1; serve = sv;
        @(posedge clk);
        model_step(1'b1, sv, int'(p1y), int'(p2y));
        #1 frame_tick = 1'b0; serve = 1'b0;
        repeat (3) begin
            @(posedge clk);
            model_step(1'b0, 1'b0, int'(p1y), int'(p2y));
            #1;
        end
        exp_q.push_back(model_obs());
    endtask

    task automatic test_reset();
        obs_t want;
        want = {10'd320, 10'd240, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0};
        checks++;
        if (dut_obs() !== want) begin
            errors++;
            $display("FAIL reset: got %s, want %s", show(dut_obs()), show(want));
        end
    endtask

    task automatic test_serve();
        obs_t e;
        serve = 1'b1;
        @(posedge clk);
        model_step(1'b0, 1'b1, 0, 0);
        #1 serve = 1'b0;
        for (int i = 0; i < 61; i++) begin
            frame(i == 10);
            e = exp_q.pop_front();
            checks++;
            if (dut_obs() !== e) begin
                errors++;
                $display("FAIL serve frame %0d: got %s, want %s", i, show(dut_obs()), show(e));
            end
        end
        checks++;
        if (ball_x !== 10'd322 || ball_y !== 10'd241 || in_play !== 1'b1) begin
            errors++;
            $display("FAIL first_move: got (%0d,%0d) play=%b, want (322,241) play=1",
                     ball_x, ball_y, in_play);
        end
    endtask

    task automatic test_rally();
        obs_t e;
        trk1 = 1; trk2 = 1;
        for (int i = 0; i < 600; i++) begin
            frame(i % 100 == 50);
            e = exp_q.pop_front();
            checks++;
            if (dut_obs() !== e) begin
                errors++;
                $display("FAIL rally frame %0d: got %s, want %s", i, show(dut_obs()), show(e));
            end
        end
    endtask

    task automatic test_miss_p2();
        obs_t e;
        int   i;
        trk1 = 0; trk2 = 1;
        for (i = 0; i < 1500 && score2 === 4'd0; i++) begin
            frame(1'b0);
            e = exp_q.pop_front();
            checks++;
            if (dut_obs() !== e) begin
                errors++;
                $display("FAIL miss frame %0d: got %s, want %s", i, show(dut_obs()), show(e));
            end
        end
        checks++;
        if (score2 !== 4'd1 || ball_x !== 10'd320 || ball_y !== 10'd240 || n_p2 !== m_np2
            || n_p1 !== m_np1) begin
            errors++;
            $display("FAIL point_p2: got s2=%0d (%0d,%0d) pulses=%0d/%0d, want s2=1 (320,240) %0d/%0d",
                     score2, ball_x, ball_y, n_p1, n_p2, m_np1, m_np2);
        end
        trk1 = 1;
        for (int k = 0; k < 61; k++) begin
            frame(1'b0);
            e = exp_q.pop_front();
            checks++;
            if (dut_obs() !== e) begin
                errors++;
                $display("FAIL reserve frame %0d: got %s, want %s", k, show(dut_obs()), show(e));
            end
        end
        checks++;
        if (ball_x !== 10'd318) begin
            errors++;
            $display("FAIL serve_toward_loser: got x=%0d, want 318", ball_x);
        end
    endtask

    task automatic test_game_over();
        obs_t       e;
        logic [9:0] fx, fy;
        trk1 = 1; trk2 = 0;
        for (int i = 0; i < 5000 && game_over !== 1'b1; i++) begin
            frame(1'b0);
            e = exp_q.pop_front();
            checks++;
            if (dut_obs() !== e) begin
                errors++;
                $display("FAIL game frame %0d: got %s, want %s", i, show(dut_obs()), show(e));
            end
        end
        checks++;
        if (game_over !== 1'b1 || score1 !== 4'd11 || in_play !== 1'b0 || n_p1 !== m_np1) begin
            errors++;
            $display("FAIL game_over: got over=%b s1=%0d pulses=%0d, want over=1 s1=11 pulses=%0d",
                     game_over, score1, n_p1, m_np1);
        end
        fx = 10'(m_x); fy = 10'(m_y);
        for (int k = 0; k < 5; k++) frame(1'b0);
        repeat (5) void'(exp_q.pop_front());
        checks++;
        if (ball_x !== fx || ball_y !== fy || game_over !== 1'b1) begin
            errors++;
            $display("FAIL frozen: got (%0d,%0d) over=%b, want (%0d,%0d) over=1",
                     ball_x, ball_y, game_over, fx, fy);
        end
        frame(1'b1);
        e = exp_q.pop_front();
        checks++;
        if (dut_obs() !== e || score1 !== 4'd0 || game_over !== 1'b0) begin
            errors++;
            $display("FAIL restart: got %s, want %s", show(dut_obs()), show(e));
        end
    endtask

    task automatic test_async_reset();
        obs_t e;
        obs_t want;
        trk1 = 1; trk2 = 1;
        for (int i = 0; i < 70; i++) begin
            frame(1'b0);
            e = exp_q.pop_front();
            checks++;
            if (dut_obs() !== e) begin
                errors++;
                $display("FAIL pre_reset frame %0d: got %s, want %s", i, show(dut_obs()), show(e));
            end
        end
        #2 rst_n = 1'b0;
        #1;
        want = {10'd320, 10'd240, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0};
        checks++;
        if (dut_obs() !== want) begin
            errors++;
            $display("FAIL async_reset: got %s, want %s", show(dut_obs()), show(want));
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        model_reset();
        frame(1'b0);
        e = exp_q.pop_front();
        checks++;
        if (dut_obs() !== e) begin
            errors++;
            $display("FAIL idle_after_reset: got %s, want %s", show(dut_obs()), show(e));
        end
    endtask

    initial begin
        rst_n = 1'b0; frame_tick = 1'b0; serve = 1'b0; p1y = '0; p2y = '0;
        model_reset();
        #12 rst_n = 1'b1;
        @(posedge clk);
        #1;
        test_reset();
        test_serve();
        test_rally();
        test_miss_p2();
        test_game_over();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
